// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Write-side valid/ready handshake into the UART transmit FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 wr_valid;
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : FIFO-buffered UART transmitter, fractional baud, parity/stop opts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    uart_tx_fifo_if.slave                    wr,
    output logic                             uart_tx,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_ACC_W = $clog2(CLK_FREQ + BAUD) + 1;
    localparam logic [c_ACC_W-1:0] c_BAUD      = c_ACC_W'(BAUD);
    localparam logic [c_ACC_W-1:0] c_CLK       = c_ACC_W'(CLK_FREQ);
    localparam logic [c_PTR_W:0]   c_FULL      = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [2:0]         c_LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]         c_LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [2:0]           r_idx;
    logic [c_ACC_W-1:0]   r_acc;
    logic                 r_tx;

    state_t               w_next;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ready;
    logic                 w_tick;
    logic [c_ACC_W-1:0]   w_sum;
    logic [c_ACC_W-1:0]   w_acc_nxt;
    logic [DATA_BITS-1:0] w_head;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [2:0]           w_idx_nxt;
    logic                 w_par_nxt;
    logic                 w_tx_nxt;

    assign w_ready     = (r_count != c_FULL);
    assign w_push      = wr.wr_valid && w_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_sum       = r_acc + c_BAUD;
    assign wr.wr_ready = w_ready;
    assign uart_tx     = r_tx;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);
    assign fifo_count  = r_count;

    // Next-state, baud accumulator and line level; the line is registered from
    // the next-state view so uart_tx lines up exactly with r_state.
    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_par_nxt   = r_par;
        w_tick      = (r_state != S_IDLE) && (w_sum >= c_CLK);
        w_acc_nxt   = (r_state == S_IDLE) ? '0 : (w_tick ? (w_sum - c_CLK) : w_sum);
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) w_pop = 1'b1;
            end
            S_START: begin
                if (w_tick) begin
                    w_next    = S_DATA;
                    w_idx_nxt = '0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_idx == c_LAST_DATA) begin
                        w_next    = (PARITY != 0) ? S_PAR : S_STOP;
                        w_idx_nxt = '0;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (w_tick) begin
                    w_next    = S_STOP;
                    w_idx_nxt = '0;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_idx == c_LAST_STOP) begin
                        if (r_count != '0) w_pop  = 1'b1;
                        else               w_next = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_pop) begin
            w_next      = S_START;
            w_shift_nxt = w_head;
            w_idx_nxt   = '0;
            w_par_nxt   = (PARITY == 1) ? ~(^w_head) : (^w_head);
            w_acc_nxt   = '0;
        end
        case (w_next)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            S_PAR:   w_tx_nxt = w_par_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_tx     <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_idx   <= w_idx_nxt;
            r_acc   <= w_acc_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Storage only; validity is tracked by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr.wr_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed scoreboard bench for uart_tx_fifo in three configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    uart_tx_fifo_if #(.DATA_BITS(8)) ifa();
    uart_tx_fifo_if #(.DATA_BITS(8)) ifb();
    uart_tx_fifo_if #(.DATA_BITS(8)) ifc();

    logic       tx_a, busy_a, tx_b, busy_b, tx_c, busy_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;

    uart_tx_fifo #(.CLK_FREQ(8), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_dut_a (.clk(clk), .rst_n(rst_n), .wr(ifa), .uart_tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));
    uart_tx_fifo #(.CLK_FREQ(8), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
        u_dut_b (.clk(clk), .rst_n(rst_n), .wr(ifb), .uart_tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));
    uart_tx_fifo #(.CLK_FREQ(10), .BAUD(3), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_dut_c (.clk(clk), .rst_n(rst_n), .wr(ifc), .uart_tx(tx_c), .busy(busy_c), .fifo_count(cnt_c));

    logic [7:0] q_a[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line for one 8E1 frame at 8 cycles per bit, index 0 = first start-bit cycle.
    function automatic logic [87:0] wave_a(input logic [7:0] d);
        logic [10:0] p;
        logic [87:0] w;
        p = {1'b1, ^d, d, 1'b0};
        for (int i = 0; i < 88; i++) w[i] = p[i/8];
        return w;
    endfunction

    task automatic write_a(input logic [7:0] d);
        int n;
        n = 0;
        ifa.wr_valid = 1'b1;
        ifa.wr_data  = d;
        while (ifa.wr_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("a_write_ready_timeout", 128'(n < 300), 128'(1'b1));
        if (n < 300) q_a.push_back(d);
        @(negedge clk);
    endtask

    task automatic drain_a(input string tag);
        int n;
        n = 0;
        while ((q_a.size() != 0 || busy_a !== 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(n < 2000), 128'(1'b1));
    endtask

    // Receiver for DUT A: checks every cycle of each frame against the queued byte.
    initial begin : mon_a
        logic [87:0] obs;
        logic [7:0]  d;
        bit          go;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_a === 1'b0) begin
                go = 1'b1;
                while (go) begin
                    go = 1'b0;
                    aborted = 1'b0;
                    chk("a_frame_expected", 128'(q_a.size() != 0), 128'(1'b1));
                    d = (q_a.size() != 0) ? q_a.pop_front() : 8'h00;
                    for (int i = 0; i < 88; i++) begin
                        if (i > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        obs[i] = tx_a;
                    end
                    if (!aborted) begin
                        chk("a_frame", 128'(obs), 128'(wave_a(d)));
                        if (q_a.size() != 0) begin
                            @(negedge clk);
                            if (rst_n === 1'b1) begin
                                chk("a_back_to_back", 128'(tx_a), 128'(1'b0));
                                go = (tx_a === 1'b0);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        int          n;
        int          len;
        logic        lvl;
        logic [95:0] obs_b;
        logic [95:0] exp_b;
        logic [11:0] pat_b;
        logic [7:0]  db;

        ifa.wr_valid = 1'b0; ifa.wr_data = '0;
        ifb.wr_valid = 1'b0; ifb.wr_data = '0;
        ifc.wr_valid = 1'b0; ifc.wr_data = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tx",    128'(tx_a),   128'(1'b1));
        chk("rst_ready", 128'(ifa.wr_ready), 128'(1'b1));
        chk("rst_busy",  128'(busy_a), 128'(1'b0));
        chk("rst_count", 128'(cnt_a),  128'(3'd0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 8E1 frame with 0xA5
        write_a(8'hA5);
        ifa.wr_valid = 1'b0;
        chk("a1_tx_after_push",    128'(tx_a),   128'(1'b1));
        chk("a1_count_after_push", 128'(cnt_a),  128'(3'd1));
        chk("a1_busy_after_push",  128'(busy_a), 128'(1'b1));
        @(negedge clk);
        chk("a1_start_latency", 128'(tx_a),  128'(1'b0));
        chk("a1_count_popped",  128'(cnt_a), 128'(3'd0));
        repeat (87) @(negedge clk);
        chk("a1_busy_last_stop", 128'(busy_a), 128'(1'b1));
        @(negedge clk);
        chk("a1_busy_drop", 128'(busy_a), 128'(1'b0));
        chk("a1_idle_tx",   128'(tx_a),   128'(1'b1));
        repeat (3) @(negedge clk);

        // Full FIFO with wr_valid held, six bytes back to back
        for (int k = 1; k <= 5; k++) write_a(8'(k));
        chk("a2_full_count", 128'(cnt_a), 128'(3'd4));
        chk("a2_full_ready", 128'(ifa.wr_ready), 128'(1'b0));
        write_a(8'h06);
        ifa.wr_valid = 1'b0;
        chk("a2_refill_count", 128'(cnt_a), 128'(3'd4));
        drain_a("a2_drain_timeout");
        repeat (3) @(negedge clk);

        // Push landing on the stop-bit tick that pops, with two bytes queued
        write_a(8'h11);
        write_a(8'h22);
        write_a(8'h33);
        ifa.wr_valid = 1'b0;
        chk("a3_count_before", 128'(cnt_a), 128'(3'd2));
        repeat (86) @(negedge clk);
        ifa.wr_valid = 1'b1;
        ifa.wr_data  = 8'h44;
        chk("a3_ready_at_tick", 128'(ifa.wr_ready), 128'(1'b1));
        q_a.push_back(8'h44);
        @(negedge clk);
        ifa.wr_valid = 1'b0;
        chk("a3_simul_count", 128'(cnt_a), 128'(3'd2));
        chk("a3_simul_b2b",   128'(tx_a),  128'(1'b0));
        drain_a("a3_drain_timeout");

        // Odd parity, two stop bits, byte 0x00
        db = 8'h00;
        pat_b = {2'b11, ~(^db), db, 1'b0};
        for (int i = 0; i < 96; i++) exp_b[i] = pat_b[i/8];
        ifb.wr_valid = 1'b1;
        ifb.wr_data  = db;
        @(negedge clk);
        ifb.wr_valid = 1'b0;
        n = 0;
        while (tx_b !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b_start_timeout", 128'(n < 10), 128'(1'b1));
        for (int i = 0; i < 96; i++) begin
            if (i > 0) @(negedge clk);
            obs_b[i] = tx_b;
        end
        chk("b_frame", 128'(obs_b), 128'(exp_b));
        @(negedge clk);
        chk("b_busy_drop", 128'(busy_b), 128'(1'b0));
        chk("b_idle_tx",   128'(tx_b),   128'(1'b1));

        // Fractional baud 10/3: bit lengths 4,3,3 repeating from the start bit
        ifc.wr_valid = 1'b1;
        ifc.wr_data  = 8'h55;
        @(negedge clk);
        ifc.wr_valid = 1'b0;
        n = 0;
        while (tx_c !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("c_start_timeout", 128'(n < 10), 128'(1'b1));
        for (int k = 0; k < 9; k++) begin
            lvl = tx_c;
            len = 0;
            while (tx_c === lvl && len < 20) begin
                @(negedge clk);
                len++;
            end
            chk($sformatf("c_bit%0d_len", k), 128'(len), 128'((k % 3 == 0) ? 4 : 3));
        end
        n = 0;
        while (busy_c !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("c_idle_timeout", 128'(n < 20), 128'(1'b1));

        // Asynchronous reset mid-frame on A
        write_a(8'h5A);
        write_a(8'hC3);
        ifa.wr_valid = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("r_tx",    128'(tx_a),   128'(1'b1));
        chk("r_ready", 128'(ifa.wr_ready), 128'(1'b1));
        chk("r_busy",  128'(busy_a), 128'(1'b0));
        chk("r_count", 128'(cnt_a),  128'(3'd0));
        q_a.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_a !== 1'b1) n++;
        end
        chk("r_quiet_after_reset", 128'(n), 128'(0));
        chk("r_busy_after_reset",  128'(busy_a), 128'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
